// File: rtl/rand_arbiter.sv
// rand_arbiter: shared bounded random-value server for the bowling game.
// One free-running 8-bit LFSR feeds every consumer; requesters are served
// round-robin through a level req / one-cycle ack handshake and receive a
// value in 1..MAXV drawn from the LFSR during the accepting DRAW cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | waiting for any req; picks first set req at/after rr_ptr
// ST_DRAW | sampling LFSR each cycle until a sample is in range (or capped)
// ST_ACK  | one-cycle ack to the granted requester; advances rr_ptr
module rand_arbiter #(
  parameter int          NREQ = 4,
  parameter int          MAXV = 4,
  parameter int          SW   = 2,
  parameter int          VW   = 3,
  parameter logic [7:0]  SEED = 8'h01
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         ack,
  output logic [VW-1:0]           rand_val,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    busy,
  output logic [7:0]              lfsr_q
);

  localparam int         IW       = $clog2(NREQ);
  // Sixteenth consecutive reject is forced into range instead of retrying.
  localparam logic [3:0] REJ_LAST = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_lfsr;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   w_rr_nxt;
  logic [IW-1:0]   r_gnt_id;
  logic [IW-1:0]   w_gnt_nxt;
  logic [IW-1:0]   w_pick;
  logic            w_pick_vld;
  logic [3:0]      r_rej_cnt;
  logic [3:0]      w_rej_nxt;
  logic [VW-1:0]   r_rand_val;
  logic [VW-1:0]   w_val_nxt;
  logic [NREQ-1:0] r_ack;
  logic [NREQ-1:0] w_ack_nxt;
  logic [NREQ-1:0] w_onehot;
  logic            r_busy;
  logic [SW-1:0]   w_s;
  logic [31:0]     w_s_u;
  logic            w_in_range;
  logic [VW-1:0]   w_val_acc;
  logic [VW-1:0]   w_val_cap;

  // Sample and candidate values derived from the LFSR as seen in this cycle.
  // The capped value folds s in MAXV..2*MAXV-1 back onto 1..MAXV.
  assign w_s        = r_lfsr[SW-1:0];
  assign w_s_u      = 32'(w_s);
  assign w_in_range = (w_s_u < 32'(MAXV));
  assign w_val_acc  = VW'(w_s_u + 32'd1);
  assign w_val_cap  = VW'(w_s_u - 32'(MAXV) + 32'd1);
  assign w_onehot   = NREQ'(1) << r_gnt_id;

  // LFSR x^8+x^6+x^5+x^4+1, free-running in every state.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  // Round-robin search: first set req at or after rr_ptr, circularly.
  // Scanning from the far end lets the nearest hit overwrite the others.
  always_comb begin
    logic [IW-1:0] idx;
    w_pick     = '0;
    w_pick_vld = 1'b0;
    idx        = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(r_rr_ptr) + k) % NREQ);
      if (req[idx]) begin
        w_pick     = idx;
        w_pick_vld = 1'b1;
      end
    end
  end

  // FSM next-state and next register values.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt_id;
    w_rr_nxt    = r_rr_ptr;
    w_rej_nxt   = r_rej_cnt;
    w_val_nxt   = r_rand_val;
    w_ack_nxt   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_gnt_nxt   = w_pick;
          w_rej_nxt   = '0;
          w_state_nxt = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (!req[r_gnt_id]) begin
          // Requester withdrew: abandon the draw, rr_ptr stays put.
          w_state_nxt = ST_IDLE;
        end else if (w_in_range) begin
          w_val_nxt   = w_val_acc;
          w_ack_nxt   = w_onehot;
          w_state_nxt = ST_ACK;
        end else if (r_rej_cnt == REJ_LAST) begin
          w_val_nxt   = w_val_cap;
          w_ack_nxt   = w_onehot;
          w_state_nxt = ST_ACK;
        end else begin
          w_rej_nxt = r_rej_cnt + 4'd1;
        end
      end
      ST_ACK: begin
        w_rr_nxt    = IW'((int'(r_gnt_id) + 1) % NREQ);
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; ack/busy are registered from next state
  // so they line up with the ACK / DRAW+ACK cycles.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_gnt_id   <= '0;
      r_rr_ptr   <= '0;
      r_rej_cnt  <= '0;
      r_rand_val <= '0;
      r_ack      <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt_id   <= w_gnt_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_rej_cnt  <= w_rej_nxt;
      r_rand_val <= w_val_nxt;
      r_ack      <= w_ack_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
    end
  end

  assign ack      = r_ack;
  assign rand_val = r_rand_val;
  assign gnt_id   = r_gnt_id;
  assign busy     = r_busy;
  assign lfsr_q   = r_lfsr;

endmodule

// File: tb/tb_rand_arbiter.sv
// Bench for rand_arbiter: two instances (MAXV=4 and MAXV=5) on one clock and
// reset, checked against a transaction-level model of grants and values.
module tb_rand_arbiter;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [3:0] req_a, req_b;
  logic [3:0] ack_a, ack_b;
  logic [2:0] val_a, val_b;
  logic [1:0] gnt_a, gnt_b;
  logic       busy_a, busy_b;
  logic [7:0] lfsr_a, lfsr_b;

  int         n_cmp;
  int         n_err;
  int         m_rr_a;
  int         m_rr_b;
  logic [7:0] m_lfsr;

  rand_arbiter #(.NREQ(4), .MAXV(4), .SW(2), .VW(3), .SEED(8'h01)) u_a (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .req      (req_a),
    .ack      (ack_a),
    .rand_val (val_a),
    .gnt_id   (gnt_a),
    .busy     (busy_a),
    .lfsr_q   (lfsr_a)
  );

  rand_arbiter #(.NREQ(4), .MAXV(5), .SW(3), .VW(3), .SEED(8'h01)) u_b (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .req      (req_b),
    .ack      (ack_b),
    .rand_val (val_b),
    .gnt_id   (gnt_b),
    .busy     (busy_b),
    .lfsr_q   (lfsr_b)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Polynomial taps 8,6,5,4 correspond to state bits 7,5,4,3 (mask B8).
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) m_lfsr <= 8'h01;
    else       m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic int pick(input logic [3:0] mask, input int rr);
    for (int k = 0; k < 4; k++) begin
      if (mask[(rr + k) % 4]) return (rr + k) % 4;
    end
    return -1;
  endfunction

  // Given the LFSR value in the cycle req is raised, return the delivered
  // value and the number of clock edges until ack is visible.
  function automatic void predict(input logic [7:0] l0, input int maxv, input int pw,
                                  output int val, output int edges);
    logic [7:0] l;
    int s;
    l = lfsr_step(l0);
    val = 0;
    edges = 0;
    for (int k = 0; k < 16; k++) begin
      s = int'(l) % pw;
      if (s < maxv) begin
        val = s + 1;
        edges = k + 2;
        return;
      end
      if (k == 15) begin
        val = s - maxv + 1;
        edges = 17;
        return;
      end
      l = lfsr_step(l);
    end
  endfunction

  task automatic test_reset();
    logic [7:0] exp_seq [5];
    exp_seq = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (6) @(negedge CLOCK_50);
    @(posedge CLOCK_50);
    #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (lfsr_a !== 8'h01) begin n_err++; $display("FAIL reset_lfsr_a: got %h want 01", lfsr_a); end
    n_cmp++;
    if (lfsr_b !== 8'h01) begin n_err++; $display("FAIL reset_lfsr_b: got %h want 01", lfsr_b); end
    n_cmp++;
    if (ack_a !== 4'b0000) begin n_err++; $display("FAIL reset_ack: got %b want 0000", ack_a); end
    n_cmp++;
    if (val_a !== 3'd0) begin n_err++; $display("FAIL reset_val: got %0d want 0", val_a); end
    n_cmp++;
    if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_cmp++;
    if (gnt_a !== 2'd0) begin n_err++; $display("FAIL reset_gnt: got %0d want 0", gnt_a); end
    @(negedge CLOCK_50);
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLOCK_50);
      if (i < 5) begin
        n_cmp++;
        if (lfsr_a !== exp_seq[i])
          begin n_err++; $display("FAIL lfsr_start[%0d]: got %h want %h", i, lfsr_a, exp_seq[i]); end
      end
      n_cmp++;
      if (lfsr_a !== m_lfsr || lfsr_a == 8'h00)
        begin n_err++; $display("FAIL lfsr_seq_a[%0d]: got %h want %h", i, lfsr_a, m_lfsr); end
      n_cmp++;
      if (lfsr_b !== m_lfsr)
        begin n_err++; $display("FAIL lfsr_seq_b[%0d]: got %h want %h", i, lfsr_b, m_lfsr); end
    end
  endtask

  task automatic test_round_robin();
    int idx, val, edges, got;
    req_a = 4'hF;
    for (int k = 0; k < 5; k++) begin
      idx = pick(req_a, m_rr_a);
      predict(m_lfsr, 4, 4, val, edges);
      got = 0;
      for (int e = 1; e <= 20 && got == 0; e++) begin
        @(negedge CLOCK_50);
        if (ack_a !== 4'b0000) got = e;
      end
      n_cmp++;
      if (got != edges)
        begin n_err++; $display("FAIL rr_latency[%0d]: ack after %0d cycles, want %0d", k, got, edges); end
      n_cmp++;
      if (ack_a !== (4'b0001 << (k % 4)) || idx != k % 4)
        begin n_err++; $display("FAIL rr_order[%0d]: ack %b want %b", k, ack_a, 4'b0001 << (k % 4)); end
      n_cmp++;
      if (val_a !== 3'(val))
        begin n_err++; $display("FAIL rr_value[%0d]: got %0d want %0d", k, val_a, val); end
      req_a[idx[1:0]] = 1'b0;
      m_rr_a = (idx + 1) % 4;
      @(negedge CLOCK_50);
      n_cmp++;
      if (ack_a !== 4'b0000 || busy_a !== 1'b0)
        begin n_err++; $display("FAIL rr_ack_width[%0d]: ack %b busy %b want 0000/0", k, ack_a, busy_a); end
      req_a[idx[1:0]] = 1'b1;
    end
    req_a = 4'h0;
    @(negedge CLOCK_50);
  endtask

  task automatic test_single();
    int idx, val, edges, got;
    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
      idx = pick(4'b0001, m_rr_a);
      predict(m_lfsr, 4, 4, val, edges);
      req_a = 4'b0001;
      got = 0;
      for (int e = 1; e <= 20 && got == 0; e++) begin
        @(negedge CLOCK_50);
        if (ack_a !== 4'b0000) got = e;
        if (e == 1) begin
          n_cmp++;
          if (busy_a !== 1'b1) begin n_err++; $display("FAIL single_busy[%0d]: got %b want 1", n, busy_a); end
        end
      end
      n_cmp++;
      if (got != edges)
        begin n_err++; $display("FAIL single_latency[%0d]: ack after %0d cycles, want %0d", n, got, edges); end
      n_cmp++;
      if (ack_a !== 4'b0001)
        begin n_err++; $display("FAIL single_ack[%0d]: got %b want 0001", n, ack_a); end
      n_cmp++;
      if (val_a !== 3'(val))
        begin n_err++; $display("FAIL single_value[%0d]: got %0d want %0d", n, val_a, val); end
      n_cmp++;
      if (gnt_a !== 2'(idx))
        begin n_err++; $display("FAIL single_gnt[%0d]: got %0d want %0d", n, gnt_a, idx); end
      req_a = 4'b0000;
      m_rr_a = (idx + 1) % 4;
      repeat ($urandom_range(1, 4)) @(negedge CLOCK_50);
      n_cmp++;
      if (ack_a !== 4'b0000 || val_a !== 3'(val))
        begin n_err++; $display("FAIL single_hold[%0d]: ack %b val %0d want 0000/%0d", n, ack_a, val_a, val); end
    end
  endtask

  task automatic test_abort();
    int idx, val, edges, got;
    @(negedge CLOCK_50);
    req_a = 4'b0100;
    idx = pick(req_a, m_rr_a);
    @(negedge CLOCK_50);
    n_cmp++;
    if (busy_a !== 1'b1 || gnt_a !== 2'(idx))
      begin n_err++; $display("FAIL abort_grant: busy %b gnt %0d want 1/%0d", busy_a, gnt_a, idx); end
    req_a = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK_50);
      n_cmp++;
      if (ack_a !== 4'b0000 || busy_a !== 1'b0)
        begin n_err++; $display("FAIL abort_noack[%0d]: ack %b busy %b want 0000/0", i, ack_a, busy_a); end
    end
    req_a = 4'b0101;
    idx = pick(req_a, m_rr_a);
    predict(m_lfsr, 4, 4, val, edges);
    got = 0;
    for (int e = 1; e <= 20 && got == 0; e++) begin
      @(negedge CLOCK_50);
      if (ack_a !== 4'b0000) got = e;
    end
    n_cmp++;
    if (ack_a !== (4'b0001 << idx) || got != edges)
      begin n_err++; $display("FAIL abort_next_grant: ack %b after %0d want %b after %0d", ack_a, got, 4'b0001 << idx, edges); end
    n_cmp++;
    if (val_a !== 3'(val))
      begin n_err++; $display("FAIL abort_next_value: got %0d want %0d", val_a, val); end
    req_a = 4'b0000;
    m_rr_a = (idx + 1) % 4;
    @(negedge CLOCK_50);
  endtask

  task automatic test_reset_mid_draw();
    int idx, val, edges, got;
    @(negedge CLOCK_50);
    req_a = 4'b1000;
    idx = pick(req_a, m_rr_a);
    @(posedge CLOCK_50);
    #2;
    n_cmp++;
    if (busy_a !== 1'b1 || gnt_a !== 2'(idx))
      begin n_err++; $display("FAIL middraw_grant: busy %b gnt %0d want 1/%0d", busy_a, gnt_a, idx); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (ack_a !== 4'b0000 || val_a !== 3'd0 || busy_a !== 1'b0 || gnt_a !== 2'd0 || lfsr_a !== 8'h01)
      begin n_err++; $display("FAIL middraw_reset: ack %b val %0d busy %b gnt %0d lfsr %h want 0000/0/0/0/01",
                              ack_a, val_a, busy_a, gnt_a, lfsr_a); end
    m_rr_a = 0;
    m_rr_b = 0;
    @(negedge CLOCK_50);
    reset = 1'b0;
    req_a = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK_50);
      n_cmp++;
      if (ack_a !== 4'b0000)
        begin n_err++; $display("FAIL middraw_noack[%0d]: got %b want 0000", i, ack_a); end
    end
    req_a = 4'b1111;
    idx = pick(req_a, m_rr_a);
    predict(m_lfsr, 4, 4, val, edges);
    got = 0;
    for (int e = 1; e <= 20 && got == 0; e++) begin
      @(negedge CLOCK_50);
      if (ack_a !== 4'b0000) got = e;
    end
    n_cmp++;
    if (ack_a !== (4'b0001 << idx) || got != edges)
      begin n_err++; $display("FAIL middraw_rr_reset: ack %b after %0d want %b after %0d", ack_a, got, 4'b0001 << idx, edges); end
    n_cmp++;
    if (val_a !== 3'(val))
      begin n_err++; $display("FAIL middraw_value: got %0d want %0d", val_a, val); end
    req_a = 4'b0000;
    m_rr_a = (idx + 1) % 4;
    @(negedge CLOCK_50);
  endtask

  task automatic test_reject();
    int idx, val, edges, got;
    int seen [8];
    logic [3:0] mask;
    for (int v = 0; v < 8; v++) seen[v] = 0;
    for (int n = 0; n < 10000; n++) begin
      mask = 4'($urandom_range(1, 15));
      idx = pick(mask, m_rr_b);
      predict(m_lfsr, 5, 8, val, edges);
      req_b = mask;
      got = 0;
      for (int e = 1; e <= 20 && got == 0; e++) begin
        @(negedge CLOCK_50);
        if (ack_b !== 4'b0000) got = e;
      end
      n_cmp++;
      if (got != edges)
        begin n_err++; $display("FAIL reject_latency[%0d]: ack after %0d cycles, want %0d", n, got, edges); end
      n_cmp++;
      if (ack_b !== (4'b0001 << idx) || gnt_b !== 2'(idx))
        begin n_err++; $display("FAIL reject_grant[%0d]: ack %b gnt %0d want %b/%0d", n, ack_b, gnt_b, 4'b0001 << idx, idx); end
      n_cmp++;
      if (val_b !== 3'(val) || val_b < 3'd1 || val_b > 3'd5)
        begin n_err++; $display("FAIL reject_value[%0d]: got %0d want %0d", n, val_b, val); end
      seen[val_b] = seen[val_b] + 1;
      req_b = 4'b0000;
      m_rr_b = (idx + 1) % 4;
      @(negedge CLOCK_50);
      n_cmp++;
      if (ack_b !== 4'b0000 || busy_b !== 1'b0)
        begin n_err++; $display("FAIL reject_ack_width[%0d]: ack %b busy %b want 0000/0", n, ack_b, busy_b); end
    end
    for (int v = 1; v <= 5; v++) begin
      n_cmp++;
      if (seen[v] == 0)
        begin n_err++; $display("FAIL reject_coverage: value %0d seen %0d times, want >0", v, seen[v]); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    m_rr_a = 0;
    m_rr_b = 0;
    req_a  = 4'b0000;
    req_b  = 4'b0000;
    test_reset();
    test_round_robin();
    test_single();
    test_abort();
    test_reset_mid_draw();
    test_reject();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
